xmos_bus_master: RTL and testbench

Byte-stream-to-address-bus initiator for the XMOS 8-bit parallel link, running in the `mm_clk` domain. It accepts command bytes from the XMOS (XMOS→FPGA direction) with a valid/ready handshake and decodes them into single-beat `wr_strobe`/`rd_strobe` transactions on the shared 31-bit address / 32-bit data bus. Read results are returned to the XMOS as a byte stream. It sits alongside the existing slaves (`led_module`, the memtest status register), and its read input is the OR-combined slave read data.

---
 rtl/xbm_pkg.sv | 25 ++
 rtl/xbm_tx_shifter.sv | 51 +++++
 rtl/xmos_bus_master.sv | 136 +++++++++++++
 tb/tb_xmos_bus_master.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbm_pkg.sv
// Shared constants, bus widths and FSM state type for the XMOS bus master.
// Optional ACK state is present only when XBM_WRITE_ACK_EN is defined.
package xbm_pkg;

   localparam int XBM_ADDR_W = 31;
   localparam int XBM_DATA_W = 32;

   localparam logic [7:0] XBM_OP_WRITE = 8'h01;
   localparam logic [7:0] XBM_OP_READ  = 8'h02;
   localparam logic [7:0] XBM_ACK_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_WR,
      ST_RD,
      ST_RDWAIT,
      ST_RESP
`ifdef XBM_WRITE_ACK_EN
      , ST_ACK
`endif
   } xbm_state_e;

endpackage

// File: rtl/xbm_tx_shifter.sv
// Serialises a 32-bit word (1 or 4 bytes, MSB-first) onto a valid/ready byte
// stream. Outputs are registered and held stable while the receiver stalls.
module xbm_tx_shifter
   import xbm_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic [XBM_DATA_W-1:0] word_i,
   input  logic                  fourBytes_i,
   input  logic                  txReady_i,
   output logic [7:0]            txData_o,
   output logic                  txValid_o,
   output logic                  lastXfer_o
);

   logic [7:0]  data_q;
   logic [23:0] rest_q;
   logic [2:0]  rem_q;
   logic        valid_q;
   logic        fire;

   assign fire       = valid_q && txReady_i;
   assign lastXfer_o = fire && (rem_q == 3'd1);
   assign txData_o   = data_q;
   assign txValid_o  = valid_q;

   // A load only arrives while idle; a transfer either retires or shifts.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= 8'h00;
         rest_q  <= 24'h0;
         rem_q   <= 3'd0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         data_q  <= word_i[31:24];
         rest_q  <= word_i[23:0];
         rem_q   <= fourBytes_i ? 3'd4 : 3'd1;
         valid_q <= 1'b1;
      end else if (fire) begin
         if (rem_q == 3'd1) begin
            valid_q <= 1'b0;
         end else begin
            data_q <= rest_q[23:16];
            rest_q <= {rest_q[15:0], 8'h00};
            rem_q  <= rem_q - 3'd1;
         end
      end
   end

endmodule

// File: rtl/xmos_bus_master.sv
// XMOS byte-stream to address-bus initiator: parses write/read packets into
// single-beat strobes and streams read data back. XBM_WRITE_ACK_EN adds a 0xA5 write ack.
module xmos_bus_master
   import xbm_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [XBM_ADDR_W-1:0] addr_bus,
   output logic [XBM_DATA_W-1:0] data_bus_wr,
   input  logic [XBM_DATA_W-1:0] data_bus_rd,
   output logic                  wr_strobe,
   output logic                  rd_strobe,
   output logic [7:0]            err_count
);

   localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

   xbm_state_e            state_q, state_d;
   logic [1:0]            byteCnt_q;
   logic [1:0]            waitCnt_q;
   logic                  isWrite_q;
   logic                  rxReady_q;
   logic                  wrStrobe_q;
   logic                  rdStrobe_q;
   logic [7:0]            errCnt_q;
   logic [XBM_ADDR_W-1:0] addr_q;
   logic [XBM_DATA_W-1:0] wdata_q;
   logic                  rxFire;
   logic                  validOp;
   logic                  loadResp;
   logic                  loadAck;
   logic                  txLast;

   assign rxFire      = rxReady_q && rx_valid;
   assign validOp     = (rx_data == XBM_OP_WRITE) || (rx_data == XBM_OP_READ);
   assign rx_ready    = rxReady_q;
   assign addr_bus    = addr_q;
   assign data_bus_wr = wdata_q;
   assign wr_strobe   = wrStrobe_q;
   assign rd_strobe   = rdStrobe_q;
   assign err_count   = errCnt_q;

   always_comb begin
      state_d  = state_q;
      loadResp = 1'b0;
      loadAck  = 1'b0;
      case (state_q)
         ST_IDLE:   if (rxFire && validOp) state_d = ST_ADDR;
         ST_ADDR:   if (rxFire && byteCnt_q == 2'd3) state_d = isWrite_q ? ST_WDATA : ST_RD;
         ST_WDATA:  if (rxFire && byteCnt_q == 2'd3) state_d = ST_WR;
`ifdef XBM_WRITE_ACK_EN
         ST_WR: begin
            loadAck = 1'b1;
            state_d = ST_ACK;
         end
         ST_ACK:    if (txLast) state_d = ST_IDLE;
`else
         ST_WR:     state_d = ST_IDLE;
`endif
         ST_RD:     state_d = ST_RDWAIT;
         ST_RDWAIT: begin
            // Capture happens on the last wait cycle, so tx_valid rises right after.
            if (waitCnt_q == LAST_WAIT) begin
               loadResp = 1'b1;
               state_d  = ST_RESP;
            end
         end
         ST_RESP:   if (txLast) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Registered outputs are derived from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         byteCnt_q  <= 2'd0;
         waitCnt_q  <= 2'd0;
         isWrite_q  <= 1'b0;
         rxReady_q  <= 1'b0;
         wrStrobe_q <= 1'b0;
         rdStrobe_q <= 1'b0;
         errCnt_q   <= 8'h00;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         rxReady_q  <= (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
         wrStrobe_q <= (state_d == ST_WR);
         rdStrobe_q <= (state_d == ST_RD);
         waitCnt_q  <= (state_q == ST_RDWAIT) ? waitCnt_q + 2'd1 : 2'd0;
         if (rxFire) begin
            case (state_q)
               ST_IDLE: begin
                  if (validOp) begin
                     isWrite_q <= (rx_data == XBM_OP_WRITE);
                     byteCnt_q <= 2'd0;
                  end else if (errCnt_q != 8'hFF) begin
                     errCnt_q <= errCnt_q + 8'd1;
                  end
               end
               ST_ADDR: begin
                  addr_q    <= {addr_q[XBM_ADDR_W-9:0], rx_data};
                  byteCnt_q <= byteCnt_q + 2'd1;
               end
               ST_WDATA: begin
                  wdata_q   <= {wdata_q[XBM_DATA_W-9:0], rx_data};
                  byteCnt_q <= byteCnt_q + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

   xbm_tx_shifter uTxShifter (
      .clk         (clk),
      .reset       (reset),
      .load_i      (loadResp || loadAck),
      .word_i      (loadAck ? {XBM_ACK_BYTE, 24'h0} : data_bus_rd),
      .fourBytes_i (!loadAck),
      .txReady_i   (tx_ready),
      .txData_o    (tx_data),
      .txValid_o   (tx_valid),
      .lastXfer_o  (txLast)
   );

endmodule

// File: tb/tb_xmos_bus_master.sv
// Directed self-checking bench for xmos_bus_master: one instance at RD_LATENCY=1
// and one at RD_LATENCY=3, selected through a shared driver mux.
module tb_xmos_bus_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        rxValid = 1'b0;
   logic [7:0]  rxData = 8'h00;
   logic        txReady = 1'b0;
   logic [31:0] slaveWord = 32'h0;

   logic        rxReady1, txValid1, wrStrobe1, rdStrobe1;
   logic [7:0]  txData1, errCnt1;
   logic [30:0] addr1;
   logic [31:0] wdata1, rdData1;
   logic        rxReady3, txValid3, wrStrobe3, rdStrobe3;
   logic [7:0]  txData3, errCnt3;
   logic [30:0] addr3;
   logic [31:0] wdata3, rdData3;
   logic        s1, s2;

   logic        rxReadyM, txValidM, wrStrobeM, rdStrobeM;
   logic [7:0]  txDataM, errCntM;
   logic [30:0] addrM;
   logic [31:0] wdataM;

   int checks = 0;
   int errors = 0;
   int wrCount = 0;
   int rdCount = 0;
   int txCount = 0;
   logic [7:0] txLastByte = 8'h00;

   always #5 clk = ~clk;

   xmos_bus_master #(.RD_LATENCY(1)) dut (
      .clk(clk), .reset(reset), .rx_data(rxData), .rx_valid(rxValid && !sel),
      .rx_ready(rxReady1), .tx_data(txData1), .tx_valid(txValid1), .tx_ready(txReady && !sel),
      .addr_bus(addr1), .data_bus_wr(wdata1), .data_bus_rd(rdData1),
      .wr_strobe(wrStrobe1), .rd_strobe(rdStrobe1), .err_count(errCnt1)
   );

   xmos_bus_master #(.RD_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .rx_data(rxData), .rx_valid(rxValid && sel),
      .rx_ready(rxReady3), .tx_data(txData3), .tx_valid(txValid3), .tx_ready(txReady && sel),
      .addr_bus(addr3), .data_bus_wr(wdata3), .data_bus_rd(rdData3),
      .wr_strobe(wrStrobe3), .rd_strobe(rdStrobe3), .err_count(errCnt3)
   );

   assign rxReadyM  = sel ? rxReady3 : rxReady1;
   assign txValidM  = sel ? txValid3 : txValid1;
   assign txDataM   = sel ? txData3 : txData1;
   assign wrStrobeM = sel ? wrStrobe3 : wrStrobe1;
   assign rdStrobeM = sel ? rdStrobe3 : rdStrobe1;
   assign errCntM   = sel ? errCnt3 : errCnt1;
   assign addrM     = sel ? addr3 : addr1;
   assign wdataM    = sel ? wdata3 : wdata1;

   // Slave models drive read data for exactly one cycle, RD_LATENCY cycles after the strobe.
   always @(posedge clk) begin
      rdData1 <= rdStrobe1 ? slaveWord : 32'h0;
      s1      <= rdStrobe3;
      s2      <= s1;
      rdData3 <= s2 ? slaveWord : 32'h0;
   end

   always @(negedge clk) begin
      if (wrStrobe1 || wrStrobe3) wrCount++;
      if (rdStrobe1 || rdStrobe3) rdCount++;
      if (txValidM && txReady) begin
         txCount++;
         txLastByte = txDataM;
      end
   end

   task automatic sendByte(input logic [7:0] b);
      bit done = 0;
      rxValid = 1'b1;
      rxData  = b;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = rxReadyM;
         @(posedge clk); #1;
      end
      rxValid = 1'b0;
      if (!done) begin
         errors++;
         $display("[TB] FAIL sendByte timeout: byte %h never accepted", b);
      end
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) sendByte(w[i*8 +: 8]);
   endtask

   task automatic waitIdle();
      bit done = 0;
      txReady = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = rxReadyM && !txValidM;
         @(posedge clk); #1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL waitIdle timeout: rx_ready=%b tx_valid=%b", rxReadyM, txValidM);
      end
   endtask

   task automatic expectBytes(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) begin
         @(negedge clk);
         checks++;
         if (txValidM !== 1'b1 || txDataM !== w[i*8 +: 8]) begin
            errors++;
            $display("[TB] FAIL resp_byte%0d: got valid=%b data=%h, want valid=1 data=%h",
                     3 - i, txValidM, txDataM, w[i*8 +: 8]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks += 7;
      if (rxReady1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_ready: got %b want 0", rxReady1); end
      if (txValid1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b want 0", txValid1); end
      if (txData1 !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h want 00", txData1); end
      if (wrStrobe1 !== 1'b0 || rdStrobe1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %b%b want 00", wrStrobe1, rdStrobe1); end
      if (addr1 !== 31'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", addr1); end
      if (wdata1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h want 0", wdata1); end
      if (errCnt1 !== 8'h00) begin errors++; $display("[TB] FAIL reset_err_count: got %h want 00", errCnt1); end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rxReady1 !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_rx_ready: got %b want 1", rxReady1); end
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      int wr0, rd0, tx0;
      wr0 = wrCount; rd0 = rdCount; tx0 = txCount;
      txReady = 1'b1;
      sendByte(8'h01);
      sendWord(32'h0000_0010);
      sendWord(32'hDEAD_BEEF);
      @(negedge clk);
      checks += 3;
      if (wrStrobe1 !== 1'b1) begin errors++; $display("[TB] FAIL write_strobe_timing: got %b want 1", wrStrobe1); end
      if (addr1 !== 31'h10) begin errors++; $display("[TB] FAIL write_addr: got %h want 00000010", addr1); end
      if (wdata1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_data: got %h want deadbeef", wdata1); end
      @(negedge clk);
      checks++;
      if (wrStrobe1 !== 1'b0) begin errors++; $display("[TB] FAIL write_strobe_width: got %b want 0", wrStrobe1); end
      repeat (8) @(negedge clk);
      checks += 3;
      if (wrCount - wr0 != 1 || rdCount - rd0 != 0) begin errors++; $display("[TB] FAIL write_strobe_count: got wr=%0d rd=%0d want wr=1 rd=0", wrCount - wr0, rdCount - rd0); end
      if (addr1 !== 31'h10) begin errors++; $display("[TB] FAIL write_addr_hold: got %h want 00000010", addr1); end
`ifdef XBM_WRITE_ACK_EN
      if (txCount - tx0 != 1 || txLastByte !== 8'hA5) begin errors++; $display("[TB] FAIL write_ack: got %0d bytes last=%h want 1 byte a5", txCount - tx0, txLastByte); end
`else
      if (txCount - tx0 != 0) begin errors++; $display("[TB] FAIL write_no_tx: got %0d bytes want 0", txCount - tx0); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      slaveWord = 32'h0000_0003;
      txReady = 1'b1;
      sendByte(8'h02);
      sendWord(32'h0200_0000);
      @(negedge clk);
      checks += 2;
      if (rdStrobe1 !== 1'b1) begin errors++; $display("[TB] FAIL read_strobe_timing: got %b want 1", rdStrobe1); end
      if (addr1 !== 31'h0200_0000) begin errors++; $display("[TB] FAIL read_addr: got %h want 02000000", addr1); end
      @(negedge clk);
      checks++;
      if (txValid1 !== 1'b0 || rdStrobe1 !== 1'b0) begin errors++; $display("[TB] FAIL read_latency: got tx_valid=%b rd_strobe=%b want 0 0", txValid1, rdStrobe1); end
      expectBytes(32'h0000_0003);
      @(negedge clk);
      checks++;
      if (txValid1 !== 1'b0 || rxReady1 !== 1'b1) begin errors++; $display("[TB] FAIL read_end: got tx_valid=%b rx_ready=%b want 0 1", txValid1, rxReady1); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [31:0] w = 32'h1122_3344;
      logic [7:0]  prevData = 8'h00;
      bit          prevStall = 0;
      int          n = 0;
      slaveWord = w;
      txReady = 1'b0;
      sendByte(8'h02);
      sendWord(32'h0000_0005);
      for (int k = 0; k < 40 && n < 4; k++) begin
         txReady = (k % 3 == 0);
         @(negedge clk);
         if (prevStall) begin
            checks++;
            if (txValid1 !== 1'b1 || txData1 !== prevData) begin errors++; $display("[TB] FAIL bp_stable: got valid=%b data=%h want valid=1 data=%h", txValid1, txData1, prevData); end
         end
         if (txValid1) begin
            checks++;
            if (rxReady1 !== 1'b0) begin errors++; $display("[TB] FAIL bp_rx_ready: got %b want 0", rxReady1); end
         end
         if (txValid1 && txReady) begin
            checks++;
            if (txData1 !== w[(3-n)*8 +: 8]) begin errors++; $display("[TB] FAIL bp_byte%0d: got %h want %h", n, txData1, w[(3-n)*8 +: 8]); end
            n++;
         end
         prevStall = txValid1 && !txReady;
         prevData  = txData1;
         @(posedge clk); #1;
      end
      txReady = 1'b0;
      @(negedge clk);
      checks += 2;
      if (n != 4) begin errors++; $display("[TB] FAIL bp_transfers: got %0d want 4", n); end
      if (rxReady1 !== 1'b1 || txValid1 !== 1'b0) begin errors++; $display("[TB] FAIL bp_end: got rx_ready=%b tx_valid=%b want 1 0", rxReady1, txValid1); end
      @(posedge clk); #1;
   endtask

   task automatic test_bad_opcode();
      int wr0;
      sendByte(8'h7F);
      @(negedge clk);
      checks++;
      if (errCnt1 !== 8'd1) begin errors++; $display("[TB] FAIL bad_op_count: got %0d want 1", errCnt1); end
      @(posedge clk); #1;
      wr0 = wrCount;
      sendByte(8'h01);
      sendWord(32'h0000_0020);
      sendWord(32'h1234_5678);
      @(negedge clk);
      checks += 2;
      if (wrStrobe1 !== 1'b1 || addr1 !== 31'h20) begin errors++; $display("[TB] FAIL bad_op_write: got strobe=%b addr=%h want 1 00000020", wrStrobe1, addr1); end
      if (wdata1 !== 32'h12345678 || errCnt1 !== 8'd1) begin errors++; $display("[TB] FAIL bad_op_write_data: got data=%h err=%0d want 12345678 1", wdata1, errCnt1); end
      @(posedge clk); #1;
      waitIdle();
      for (int i = 0; i < 253; i++) sendByte(8'hFF);
      @(negedge clk);
      checks++;
      if (errCnt1 !== 8'hFE) begin errors++; $display("[TB] FAIL bad_op_254: got %h want fe", errCnt1); end
      @(posedge clk); #1;
      for (int i = 0; i < 46; i++) sendByte(8'h00);
      @(negedge clk);
      checks += 2;
      if (errCnt1 !== 8'hFF) begin errors++; $display("[TB] FAIL bad_op_saturate: got %h want ff", errCnt1); end
      if (wrCount - wr0 != 1) begin errors++; $display("[TB] FAIL bad_op_wr_count: got %0d want 1", wrCount - wr0); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      int rd0, wr0;
      sendByte(8'h02);
      sendByte(8'hAA);
      sendByte(8'hBB);
      sendByte(8'hCC);
      rd0 = rdCount; wr0 = wrCount;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) @(negedge clk);
      checks += 2;
      if (rdCount != rd0 || wrCount != wr0) begin errors++; $display("[TB] FAIL abort_no_strobe: got rd=%0d wr=%0d want 0 0", rdCount - rd0, wrCount - wr0); end
      if (errCnt1 !== 8'h00 || rxReady1 !== 1'b1) begin errors++; $display("[TB] FAIL abort_state: got err=%h rx_ready=%b want 00 1", errCnt1, rxReady1); end
      @(posedge clk); #1;
      slaveWord = 32'hCAFE_F00D;
      txReady = 1'b1;
      sendByte(8'h02);
      sendWord(32'h0000_0040);
      @(negedge clk);
      checks++;
      if (rdStrobe1 !== 1'b1 || addr1 !== 31'h40) begin errors++; $display("[TB] FAIL abort_new_read: got strobe=%b addr=%h want 1 00000040", rdStrobe1, addr1); end
      @(negedge clk);
      expectBytes(32'hCAFE_F00D);
      checks++;
      if (rdCount - rd0 != 1) begin errors++; $display("[TB] FAIL abort_rd_count: got %0d want 1", rdCount - rd0); end
      @(posedge clk); #1;
      waitIdle();
   endtask

   task automatic test_abort_response();
      bit seen = 0;
      slaveWord = 32'h0BAD_0BAD;
      txReady = 1'b0;
      sendByte(8'h02);
      sendWord(32'h0000_0008);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = txValid1;
         @(posedge clk); #1;
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL abort_resp_start: got tx_valid=0 want 1"); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (txValid1 !== 1'b0 || rxReady1 !== 1'b0) begin errors++; $display("[TB] FAIL abort_resp_drop: got tx_valid=%b rx_ready=%b want 0 0", txValid1, rxReady1); end
      @(posedge clk); #1;
      waitIdle();
   endtask

   task automatic test_latency3();
      sel = 1'b1;
      slaveWord = 32'h5A5A_A5A5;
      txReady = 1'b1;
      sendByte(8'h02);
      sendWord(32'h8000_0004);
      @(negedge clk);
      checks++;
      if (rdStrobe3 !== 1'b1 || addr3 !== 31'h4) begin errors++; $display("[TB] FAIL lat3_strobe: got strobe=%b addr=%h want 1 00000004", rdStrobe3, addr3); end
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if (txValid3 !== 1'b0) begin errors++; $display("[TB] FAIL lat3_wait%0d: got tx_valid=%b want 0", i, txValid3); end
      end
      expectBytes(32'h5A5A_A5A5);
      @(posedge clk); #1;
      waitIdle();
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_bad_opcode();
      test_abort();
      test_abort_response();
      test_latency3();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
